train_sequencer: RTL and testbench
==================================

// Module: train_sequencer
// PURPOSE
//  Top-level loop sequencer for the Axiline linear-model training datapath.
//  For every sample of every epoch it streams NumCycle feature/weight chunks into the dot-product pipe.
//  It drives the accumulator select (0 = init, 1 = accumulate), waits out the pipe latency and flags the gradient.
//  It then writes back NumCycle updated weight chunks under a ready handshake.
//  Sits between the host start/config interface and the chunk memories / MAC array.
// PARAMETERS
//  logNumCycle  3   width of chunk index
//  NumCycle     8   chunks per feature vector (2**logNumCycle)
//  PipeLat      4   cycles from last chunk read to gradient available at MAC output (>=1)
//  SampleW      16  width of sample count / index
// PORTS
//  clk          in   1            single clock, rising edge
//  rst          in   1            asynchronous, active-high reset
//  start        in   1            start request; honoured only in IDLE
//  num_samples  in   SampleW      samples per epoch, captured on accepted start
//  num_epochs   in   8            epochs to run, captured on accepted start
//  upd_ready    in   1            weight memory accepts a write-back chunk this cycle
//  rd_en        out  1            chunk read strobe to feature/weight memories
//  rd_chunk     out  logNumCycle  chunk index being read
//  sel          out  1            MAC accumulator select: 0 = load, 1 = accumulate
//  sample_idx   out  SampleW      current sample index (read address high part)
//  grad_valid   out  1            one-cycle pulse: gradient for current sample ready
//  wr_en        out  1            weight write-back request
//  wr_chunk     out  logNumCycle  chunk index being written back
//  busy         out  1            high in every state except IDLE
//  done         out  1            one-cycle pulse at end of last epoch
// BEHAVIOUR
//  - All outputs are registered; on rst every output is 0 and state = IDLE, with no done pulse.
//  - rst asserted mid-run aborts immediately; the next run needs a new start.
//  - States: IDLE, FETCH, DRAIN, UPDATE, NEXT.
//  - IDLE: start=1 captures num_samples/num_epochs and clears sample_idx and the epoch counter.
//    - If either count is 0: done=1 for the next cycle, stay in IDLE, no rd_en.
//    - Otherwise go to FETCH; rd_en is first high the cycle after start.
//  - FETCH: NumCycle consecutive cycles with rd_en=1 and rd_chunk=0..NumCycle-1.
//    - sel=0 when rd_chunk==0, sel=1 otherwise.
//    - After chunk NumCycle-1, go to DRAIN.
//  - DRAIN: exactly PipeLat cycles with rd_en=0 (sel holds 1).
//    - grad_valid=1 on the last DRAIN cycle only, then go to UPDATE.
//  - UPDATE: wr_en=1 and wr_chunk starts at 0.
//    - A chunk transfers on a cycle with wr_en&&upd_ready; wr_chunk then increments.
//    - With upd_ready=0, wr_en and wr_chunk hold unchanged (no timeout).
//    - Transfer of chunk NumCycle-1 leads to NEXT, with wr_en=0 there.
//  - NEXT: one cycle, all strobes 0.
//    - If sample_idx != num_samples-1: sample_idx++ and go to FETCH.
//    - Else if epoch != num_epochs-1: epoch++, sample_idx=0, go to FETCH.
//    - Else: done=1 for one cycle concurrent with entering IDLE; busy drops in the same cycle.
//  - Per-sample cost with upd_ready tied 1 is 2*NumCycle+PipeLat+1 cycles (21 at defaults).
//  - start while busy is ignored; num_* changes while busy have no effect.
//  - rd_en and wr_en are never high in the same cycle.
//  - Counters wrap only via the explicit transitions above; no modulo arithmetic on indices.
// TESTING
//  1. Reset: rst pulse mid-FETCH -> all outputs 0 asynchronously; rst release + start -> run restarts at sample 0.
//  2. num_samples=1, num_epochs=1, upd_ready=1, start at cycle 0:
//     - rd_en cycles 1-8, sel=0 only at cycle 1.
//     - grad_valid at cycle 12, wr_en cycles 13-20, done at cycle 22.
//  3. num_samples=3, num_epochs=2, upd_ready=1 -> sample_idx sequence 0,1,2,0,1,2; exactly 6 grad_valid pulses, 1 done.
//  4. upd_ready held 0 for 5 cycles at wr_chunk=3 -> wr_en=1 and wr_chunk=3 stable; total run grows by exactly 5 cycles.
//  5. num_samples=0 with start -> done pulse next cycle, rd_en never asserted, busy stays 0.
//  6. start re-pulsed during DRAIN -> ignored; sample_idx/timing identical to the run without the extra pulse.

Source files
------------

// File: rtl/train_sequencer_if.sv
// Bundle between the host/memories/MAC array and the training loop sequencer.
// Ports: host config (start, num_samples, num_epochs), write-back ready, read/write strobes, status.
interface train_sequencer_if #(
   parameter int logNumCycle = 3,
   parameter int SampleW     = 16
);
   logic                   start;
   logic [SampleW-1:0]     num_samples;
   logic [7:0]             num_epochs;
   logic                   upd_ready;
   logic                   rd_en;
   logic [logNumCycle-1:0] rd_chunk;
   logic                   sel;
   logic [SampleW-1:0]     sample_idx;
   logic                   grad_valid;
   logic                   wr_en;
   logic [logNumCycle-1:0] wr_chunk;
   logic                   busy;
   logic                   done;

   modport slave (
      input  start, num_samples, num_epochs, upd_ready,
      output rd_en, rd_chunk, sel, sample_idx, grad_valid,
      output wr_en, wr_chunk, busy, done
   );

   modport master (
      output start, num_samples, num_epochs, upd_ready,
      input  rd_en, rd_chunk, sel, sample_idx, grad_valid,
      input  wr_en, wr_chunk, busy, done
   );
endinterface

// File: rtl/train_sequencer.sv
// Epoch/sample loop sequencer: chunk reads, pipe drain, gradient flag, weight write-back.
// Ports: clk, rst (async, active-high), bus (slave side of train_sequencer_if); all outputs registered.
module train_sequencer #(
   parameter int logNumCycle = 3,
   parameter int NumCycle    = 8,
   parameter int PipeLat     = 4,
   parameter int SampleW     = 16
) (
   input  logic               clk,
   input  logic               rst,
   train_sequencer_if.slave   bus
);
   localparam int DW = $clog2(PipeLat + 1);
   localparam logic [logNumCycle-1:0] LAST  = logNumCycle'(NumCycle - 1);
   localparam logic [DW-1:0]          DLAST = DW'(PipeLat - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DRAIN, S_UPDATE, S_NEXT
   } state_t;

   state_t                 state_q, state_d;
   logic [logNumCycle-1:0] rdc_q, rdc_d;
   logic [logNumCycle-1:0] wrc_q, wrc_d;
   logic [DW-1:0]          drn_q, drn_d;
   logic [SampleW-1:0]     smp_q, smp_d;
   logic [SampleW-1:0]     ns_q, ns_d;
   logic [7:0]             ep_q, ep_d;
   logic [7:0]             ne_q, ne_d;
   logic                   rd_q, rd_d;
   logic                   sel_q, sel_d;
   logic                   gv_q, gv_d;
   logic                   wr_q, wr_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   always_comb begin
      state_d = state_q;
      rdc_d   = rdc_q;
      wrc_d   = wrc_q;
      drn_d   = drn_q;
      smp_d   = smp_q;
      ns_d    = ns_q;
      ep_d    = ep_q;
      ne_d    = ne_q;
      rd_d    = 1'b0;
      sel_d   = sel_q;
      gv_d    = 1'b0;
      wr_d    = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               ns_d  = bus.num_samples;
               ne_d  = bus.num_epochs;
               smp_d = '0;
               ep_d  = '0;
               if (bus.num_samples == '0 || bus.num_epochs == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_FETCH;
                  rd_d    = 1'b1;
                  rdc_d   = '0;
                  sel_d   = 1'b0;
               end
            end
         end
         S_FETCH: begin
            sel_d = 1'b1;
            if (rdc_q == LAST) begin
               state_d = S_DRAIN;
               drn_d   = '0;
               // single-cycle drain flags the gradient immediately
               gv_d    = (PipeLat == 1);
            end else begin
               rd_d  = 1'b1;
               rdc_d = rdc_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (drn_q == DLAST) begin
               state_d = S_UPDATE;
               wr_d    = 1'b1;
               wrc_d   = '0;
            end else begin
               drn_d = drn_q + 1'b1;
               gv_d  = (drn_q + 1'b1 == DLAST);
            end
         end
         S_UPDATE: begin
            wr_d = 1'b1;
            if (bus.upd_ready) begin
               if (wrc_q == LAST) begin
                  state_d = S_NEXT;
                  wr_d    = 1'b0;
               end else begin
                  wrc_d = wrc_q + 1'b1;
               end
            end
         end
         S_NEXT: begin
            if (smp_q != ns_q - 1'b1) begin
               smp_d   = smp_q + 1'b1;
               state_d = S_FETCH;
            end else if (ep_q != ne_q - 1'b1) begin
               ep_d    = ep_q + 1'b1;
               smp_d   = '0;
               state_d = S_FETCH;
            end else begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
            if (state_d == S_FETCH) begin
               rd_d  = 1'b1;
               rdc_d = '0;
               sel_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         rdc_q   <= '0;
         wrc_q   <= '0;
         drn_q   <= '0;
         smp_q   <= '0;
         ns_q    <= '0;
         ep_q    <= '0;
         ne_q    <= '0;
         rd_q    <= 1'b0;
         sel_q   <= 1'b0;
         gv_q    <= 1'b0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rdc_q   <= rdc_d;
         wrc_q   <= wrc_d;
         drn_q   <= drn_d;
         smp_q   <= smp_d;
         ns_q    <= ns_d;
         ep_q    <= ep_d;
         ne_q    <= ne_d;
         rd_q    <= rd_d;
         sel_q   <= sel_d;
         gv_q    <= gv_d;
         wr_q    <= wr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.rd_en      = rd_q;
   assign bus.rd_chunk   = rdc_q;
   assign bus.sel        = sel_q;
   assign bus.sample_idx = smp_q;
   assign bus.grad_valid = gv_q;
   assign bus.wr_en      = wr_q;
   assign bus.wr_chunk   = wrc_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_train_sequencer.sv
// Directed bench for train_sequencer: timing, loop order, stalls, zero counts, reset.
// Drives the master side of train_sequencer_if; expectations are hand-derived cycle numbers.
module tb_train_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   train_sequencer_if #(.logNumCycle(3), .SampleW(16)) bus();

   train_sequencer #(
      .logNumCycle(3), .NumCycle(8), .PipeLat(4), .SampleW(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic       tr_rd[0:511];
   logic       tr_wr[0:511];
   logic       tr_gv[0:511];
   logic       tr_dn[0:511];
   logic       tr_by[0:511];
   logic       tr_sel[0:511];
   logic [2:0] tr_rc[0:511];
   logic [2:0] tr_wc[0:511];
   int         gidx[0:15];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [27:0] outs();
      return {bus.rd_en, bus.rd_chunk, bus.sel, bus.sample_idx,
              bus.grad_valid, bus.wr_en, bus.wr_chunk, bus.busy, bus.done};
   endfunction

   // Start a run at cycle 0 and observe cycles 1.. until 3 cycles past done.
   task automatic run(input int ns, input int ne, input int stall_chunk,
                      input int stall_len, input int restart_cyc,
                      output int done_cyc, output int grads, output int dones,
                      output int rds, output int busys, output int overlap);
      int c;
      int extra;
      int rem;
      bit held;
      done_cyc = -1;
      grads = 0;
      dones = 0;
      rds = 0;
      busys = 0;
      overlap = 0;
      rem = stall_len;
      held = 1'b0;
      c = 0;
      extra = -1;
      bus.num_samples = 16'(ns);
      bus.num_epochs = 8'(ne);
      bus.upd_ready = 1'b1;
      bus.start = 1'b1;
      while (c < 3000 && extra != 0) begin
         tick();
         c++;
         bus.start = (c == restart_cyc);
         if (extra > 0) extra--;
         if (c < 512) begin
            tr_rd[c] = bus.rd_en;
            tr_wr[c] = bus.wr_en;
            tr_gv[c] = bus.grad_valid;
            tr_dn[c] = bus.done;
            tr_by[c] = bus.busy;
            tr_sel[c] = bus.sel;
            tr_rc[c] = bus.rd_chunk;
            tr_wc[c] = bus.wr_chunk;
         end
         if (bus.rd_en) rds++;
         if (bus.busy) busys++;
         if (bus.rd_en && bus.wr_en) overlap++;
         if (bus.grad_valid) begin
            if (grads < 16) gidx[grads] = int'(bus.sample_idx);
            grads++;
         end
         if (bus.done) begin
            dones++;
            if (done_cyc < 0) begin
               done_cyc = c;
               extra = 3;
            end
         end
         if (held) begin
            check("stall_hold", {28'd0, bus.wr_en, bus.wr_chunk},
                  {28'd0, 1'b1, 3'(stall_chunk)});
         end
         held = 1'b0;
         bus.upd_ready = 1'b1;
         if (rem > 0 && bus.wr_en && bus.wr_chunk == 3'(stall_chunk)) begin
            bus.upd_ready = 1'b0;
            rem--;
            held = 1'b1;
         end
      end
      bus.start = 1'b0;
      bus.upd_ready = 1'b1;
      if (done_cyc < 0) check("timeout", 0, 1);
   endtask

   initial begin
      int dc, g, d, r, b, o;
      int n;
      bus.start = 1'b0;
      bus.num_samples = '0;
      bus.num_epochs = '0;
      bus.upd_ready = 1'b1;

      // reset state
      tick();
      tick();
      check("reset_outs", {4'd0, outs()}, 32'd0);
      rst = 1'b0;
      tick();

      // run 1, basic timing
      run(1, 1, 0, 0, 0, dc, g, d, r, b, o);
      check("t2_done_cyc", dc, 22);
      check("t2_grads", g, 1);
      check("t2_dones", d, 1);
      for (int c = 1; c <= 23; c++) begin
         logic [4:0] ev;
         ev = {(c >= 1 && c <= 8), (c >= 13 && c <= 20), (c == 12),
               (c == 22), (c >= 1 && c <= 21)};
         check($sformatf("t2_cyc%0d", c),
               {27'd0, tr_rd[c], tr_wr[c], tr_gv[c], tr_dn[c], tr_by[c]},
               {27'd0, ev});
      end
      for (int c = 1; c <= 8; c++) begin
         check($sformatf("t2_rdc%0d", c), {29'd0, tr_rc[c]}, c - 1);
         check($sformatf("t2_sel%0d", c), {31'd0, tr_sel[c]}, (c == 1) ? 0 : 1);
      end
      for (int c = 13; c <= 20; c++) begin
         check($sformatf("t2_wrc%0d", c), {29'd0, tr_wc[c]}, c - 13);
      end

      // loop order: 3 samples x 2 epochs
      run(3, 2, 0, 0, 0, dc, g, d, r, b, o);
      check("t3_done_cyc", dc, 127);
      check("t3_grads", g, 6);
      check("t3_dones", d, 1);
      check("t3_rds", r, 48);
      check("t3_overlap", o, 0);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t3_idx%0d", i), gidx[i], i % 3);
      end

      // write-back stall of 5 cycles at chunk 3
      run(1, 1, 3, 5, 0, dc, g, d, r, b, o);
      check("t4_done_cyc", dc, 27);
      check("t4_grads", g, 1);
      check("t4_overlap", o, 0);

      // zero counts
      run(0, 1, 0, 0, 0, dc, g, d, r, b, o);
      check("t5_done_cyc", dc, 1);
      check("t5_rds", r, 0);
      check("t5_busy", b, 0);
      check("t5_dones", d, 1);
      run(2, 0, 0, 0, 0, dc, g, d, r, b, o);
      check("t5e_done_cyc", dc, 1);
      check("t5e_rds", r, 0);

      // start re-pulsed during DRAIN of sample 0
      run(3, 2, 0, 0, 10, dc, g, d, r, b, o);
      check("t6_done_cyc", dc, 127);
      check("t6_grads", g, 6);
      check("t6_dones", d, 1);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t6_idx%0d", i), gidx[i], i % 3);
      end

      // async reset mid-FETCH of sample 1
      bus.num_samples = 16'd3;
      bus.num_epochs = 8'd1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (n < 100 && !(bus.rd_en && bus.sample_idx == 16'd1 &&
                          bus.rd_chunk == 3'd2)) begin
         tick();
         n++;
      end
      check("t1_reach", {31'd0, (n < 100)}, 1);
      #3 rst = 1'b1;
      #1;
      check("t1_async_outs", {4'd0, outs()}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("t1_idle", {4'd0, outs()}, 32'd0);
      run(2, 1, 0, 0, 0, dc, g, d, r, b, o);
      check("t1_done_cyc", dc, 43);
      check("t1_grads", g, 2);
      check("t1_idx0", gidx[0], 0);
      check("t1_idx1", gidx[1], 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
